// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: two-flop synchroniser, oversampled midpoint sampling,
// one-cycle strobes for good bytes (rxValid) and bad stop bits (frameErr).
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       baudClk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       frameErr,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        WAIT_IDLE
    } state_t;

    state_t          state;
    logic            rxM;
    logic            rxS;
    logic [CW-1:0]   sampleCnt;
    logic [2:0]      bitIdx;
    logic [7:0]      shiftReg;

    // Sync flops reset high so a reset never looks like a start bit.
    always_ff @(posedge baudClk) begin
        if (reset) begin
            rxM <= 1'b1;
            rxS <= 1'b1;
        end else begin
            rxM <= rx;
            rxS <= rxM;
        end
    end

    always_ff @(posedge baudClk) begin
        if (reset) begin
            state     <= IDLE;
            sampleCnt <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            rxData    <= '0;
            rxValid   <= 1'b0;
            frameErr  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
            case (state)
                IDLE: begin
                    sampleCnt <= '0;
                    bitIdx    <= '0;
                    if (!rxS) begin
                        state <= START_BIT;
                        busy  <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (sampleCnt == HALF_M1) begin
                        sampleCnt <= '0;
                        if (!rxS) begin
                            state <= DATA_BITS;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        sampleCnt <= sampleCnt + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (sampleCnt == FULL_M1) begin
                        shiftReg[bitIdx] <= rxS;
                        sampleCnt        <= '0;
                        if (bitIdx == 3'd7) begin
                            bitIdx <= '0;
                            state  <= STOP_BIT;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                        end
                    end else begin
                        sampleCnt <= sampleCnt + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (sampleCnt == FULL_M1) begin
                        sampleCnt <= '0;
                        if (rxS) begin
                            rxData  <= shiftReg;
                            rxValid <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            frameErr <= 1'b1;
                            state    <= WAIT_IDLE;
                        end
                    end else begin
                        sampleCnt <= sampleCnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low (break) line must not be taken as a new start bit.
                    if (rxS) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    sampleCnt <= '0;
                    bitIdx    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: hand-computed bytes, strobe timing and
// error handling, with a bench-side serializer acting as the transmitter.
module tb_uart_receiver;

    localparam int OS = 16;

    logic       baudClk = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameErr;
    logic       busy;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int t0   = 0;

    logic [7:0] vdata[$];
    int         vcyc[$];
    int         ecyc[$];

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .baudClk (baudClk),
        .reset   (reset),
        .rx      (rx),
        .rxData  (rxData),
        .rxValid (rxValid),
        .frameErr(frameErr),
        .busy    (busy)
    );

    always #5 baudClk = ~baudClk;

    always @(posedge baudClk) cyc <= cyc + 1;

    // Log every strobe cycle; cyc here equals the index of the preceding edge.
    always @(negedge baudClk) begin
        if (rxValid) begin
            vdata.push_back(rxData);
            vcyc.push_back(cyc);
        end
        if (frameErr) ecyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge baudClk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (OS) @(posedge baudClk);
        #1;
    endtask

    // Called #1 after an edge; records t0 as the edge that first samples the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stopb);
        t0 = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stopb);
    endtask

    task automatic clear_log();
        vdata.delete();
        vcyc.delete();
        ecyc.delete();
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        #0;
        check("reset_rxData", rxData, 8'h00);
        check("reset_rxValid", rxValid, 1'b0);
        check("reset_frameErr", frameErr, 1'b0);
        check("reset_busy", busy, 1'b0);
        idle(5);

        // Good frame 0xA5
        clear_log();
        send_frame(8'hA5, 1'b1);
        idle(4);
        check("good_count", vdata.size(), 1);
        if (vdata.size() == 1) begin
            check("good_data", vdata[0], 8'hA5);
            check("good_latency", vcyc[0] - t0, 154);
        end
        check("good_frameErr", ecyc.size(), 0);
        check("good_busy", busy, 1'b0);
        check("good_rxData_hold", rxData, 8'hA5);

        // 3-cycle start glitch
        clear_log();
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(2);
        check("glitch_busy_mid", busy, 1'b1);
        idle(20);
        check("glitch_busy_end", busy, 1'b0);
        check("glitch_valid", vdata.size(), 0);
        check("glitch_err", ecyc.size(), 0);
        check("glitch_rxData", rxData, 8'hA5);

        // 0x3C with low stop bit, then a 40-cycle break
        clear_log();
        send_frame(8'h3C, 1'b0);
        idle(40);
        check("badstop_err_count", ecyc.size(), 1);
        if (ecyc.size() == 1) check("badstop_err_time", ecyc[0] - t0, 154);
        check("badstop_valid", vdata.size(), 0);
        check("badstop_rxData", rxData, 8'hA5);
        check("badstop_wait_busy", busy, 1'b1);
        rx = 1'b1;
        idle(10);
        check("badstop_release_busy", busy, 1'b0);
        idle(200);
        check("badstop_no_spurious_valid", vdata.size(), 0);
        check("badstop_no_spurious_err", ecyc.size(), 1);

        // Back-to-back 0x00, 0xFF
        clear_log();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(4);
        check("b2b_count", vdata.size(), 2);
        if (vdata.size() == 2) begin
            check("b2b_data0", vdata[0], 8'h00);
            check("b2b_data1", vdata[1], 8'hFF);
            check("b2b_spacing", vcyc[1] - vcyc[0], 160);
        end
        check("b2b_err", ecyc.size(), 0);

        // Reset during data bit 4 of 0x81; the line is released with the reset
        clear_log();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx = 1'b0;
        idle(8);
        check("midrst_busy_before", busy, 1'b1);
        reset = 1'b1;
        rx    = 1'b1;
        idle(1);
        reset = 1'b0;
        check("midrst_rxData", rxData, 8'h00);
        check("midrst_rxValid", rxValid, 1'b0);
        check("midrst_frameErr", frameErr, 1'b0);
        check("midrst_busy", busy, 1'b0);
        idle(200);
        check("midrst_no_valid", vdata.size(), 0);
        check("midrst_no_err", ecyc.size(), 0);
        send_frame(8'h5A, 1'b1);
        idle(4);
        check("midrst_next_count", vdata.size(), 1);
        if (vdata.size() == 1) check("midrst_next_data", vdata[0], 8'h5A);

        // Serializer loopback 0x01, 0x80, 0x55
        clear_log();
        send_frame(8'h01, 1'b1);
        send_frame(8'h80, 1'b1);
        idle(7);
        send_frame(8'h55, 1'b1);
        idle(20);
        check("loop_count", vdata.size(), 3);
        if (vdata.size() == 3) begin
            check("loop_data0", vdata[0], 8'h01);
            check("loop_data1", vdata[1], 8'h80);
            check("loop_data2", vdata[2], 8'h55);
        end
        check("loop_err", ecyc.size(), 0);
        check("loop_rxData", rxData, 8'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage; consumes the line driven by the UART transmitter's `tx` output. Deserialises 8N1 frames (one low start bit, 8 data bits LSB first, one high stop bit) using an oversampling clock. Each good byte is presented on `rxData` with a one-cycle `rxValid` strobe. Framing errors are flagged with `frameErr` and the corrupt byte is discarded.

## Interface
- `OVERSAMPLE`, default 16: `baudClk` cycles per bit. Must be even and ≥ 4.
- `baudClk`, input, 1: the single clock, running at `OVERSAMPLE` × bit rate. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `rx`, input, 1: asynchronous serial line; idles high.
- `rxData`, output, 8: last good received byte. Holds its value until the next good frame.
- `rxValid`, output, 1: one-cycle pulse when `rxData` is updated.
- `frameErr`, output, 1: one-cycle pulse when the stop bit samples low.
- `busy`, output, 1: high whenever state ≠ IDLE.

## Operation
- **Synchroniser:** `rx` passes through two flops (reset value 1); `rxS` is the second flop. Only `rxS` is used by the FSM.
- **Counters:**
  - `sampleCnt`: width `$clog2(OVERSAMPLE)`.
  - `bitIdx`: 3 bits.
  - `shiftReg`: 8 bits.
- **States:** IDLE, START_BIT, DATA_BITS, STOP_BIT, WAIT_IDLE.
- **IDLE:** `sampleCnt`=0, `bitIdx`=0. When `rxS`==0, go to START_BIT.
- **START_BIT:** at each edge, if `sampleCnt`==`OVERSAMPLE`/2−1, check the midpoint:
  - `rxS`==0: go to DATA_BITS with `sampleCnt`=0.
  - `rxS`==1: glitch; return to IDLE with no output activity.
  - Otherwise `sampleCnt`++.
- **DATA_BITS:** when `sampleCnt`==`OVERSAMPLE`−1:
  - Write `shiftReg[bitIdx]` ← `rxS` and set `sampleCnt`=0.
  - If `bitIdx`==7, set `bitIdx`=0 and go to STOP_BIT; else `bitIdx`++.
  - Otherwise `sampleCnt`++.
- **STOP_BIT:** when `sampleCnt`==`OVERSAMPLE`−1:
  - `rxS`==1: `rxData` ← `shiftReg`, pulse `rxValid`, go to IDLE.
  - `rxS`==0: pulse `frameErr`, leave `rxData` unchanged, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rxS`==1, then go to IDLE. This prevents a break condition (line held low) from retriggering frames.
- **Illegal state encoding:** go to IDLE.
- **Reset values:** `rxData`=0, `rxValid`=0, `frameErr`=0, `busy`=0, state=IDLE, counters=0, `shiftReg`=0, sync flops=1.
- **Reset mid-frame:** on the next edge, abort to the reset values. The partial byte is lost and no strobe is emitted.
- **Strobes:** `rxValid` and `frameErr` are each high for exactly one cycle and are never asserted together.
- **Back-to-back frames:** the next start bit may begin the cycle after the stop-bit sample. IDLE detects it with no gap requirement.

## Timing
- Let t0 be the `baudClk` edge that first samples `rx` low into sync flop 1.
  - `rxS` goes low after edge t0+1.
  - IDLE sees `rxS` low at edge t0+2 and enters START_BIT.
- Start midpoint check at edge t0+2+`OVERSAMPLE`/2 (t0+10 for 16).
- Data bit k is sampled at edge t0+2+`OVERSAMPLE`/2+(k+1)·`OVERSAMPLE` (bit 0 at t0+26, bit 7 at t0+138 for 16).
- Stop bit sampled at edge t0+2+`OVERSAMPLE`/2+9·`OVERSAMPLE` (t0+154).
  - `rxValid` or `frameErr` is high for the cycle following that edge.
- `busy` rises after edge t0+2 and falls after the stop-sample edge (good frame) or after the exit from WAIT_IDLE.
- Minimum start-pulse width accepted: > `OVERSAMPLE`/2 cycles.

## Test plan
- **Good frame:** idle line, then send 0xA5 at 16 cycles/bit → `rxData`=0xA5, `rxValid` high for exactly 1 cycle, 154 cycles after the first low sample, `frameErr`=0.
- **Start glitch:** 3-cycle low pulse on an idle line → START_BIT aborts at its midpoint, `busy` returns to 0, no `rxValid`, `rxData` unchanged.
- **Bad stop bit:** send 0x3C with the stop bit driven low, then hold `rx` low 40 cycles and release → one `frameErr` pulse, `rxData` keeps its previous value, FSM stays in WAIT_IDLE until `rx` goes high, and no spurious frame follows.
- **Back-to-back frames:** send 0x00 then 0xFF with zero idle gap → two `rxValid` pulses 160 cycles apart, `rxData` 0x00 then 0xFF.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 4 of 0x81 → all outputs return to reset values and no `rxValid`; a following 0x5A frame is received correctly.
- **Loopback:** drive `rx` from the transmitter's `tx` at matched rates and send 0x01, 0x80, 0x55 → each byte is reproduced on `rxData` in order, with no `frameErr`.
